// File: rtl/fft_pkg.sv
// fft_pkg: shared state type, complex pack/unpack helpers and twiddle format for fft_iter.
package fft_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    localparam int CMAX = 64;
    localparam int TW_INT_BITS = 2;
    localparam real PI = 3.14159265358979323846;
    typedef logic [CMAX-1:0] cplx_t;
    typedef logic signed [CMAX/2-1:0] half_t;

    // Twiddles are Q1.(h-2): +1.0 is 2^tw_frac(h).
    function automatic int tw_frac(input int h);
        return h - TW_INT_BITS;
    endfunction

    function automatic half_t c_re(input cplx_t x, input int h);
        half_t r;
        r = half_t'(x >> h);
        return (r <<< (CMAX / 2 - h)) >>> (CMAX / 2 - h);
    endfunction

    function automatic half_t c_im(input cplx_t x, input int h);
        half_t r;
        r = half_t'(x);
        return (r <<< (CMAX / 2 - h)) >>> (CMAX / 2 - h);
    endfunction

    function automatic cplx_t c_pack(input half_t re, input half_t im, input int h);
        cplx_t m;
        m = (cplx_t'(1) << h) - cplx_t'(1);
        return ((cplx_t'(re) & m) << h) | (cplx_t'(im) & m);
    endfunction

    function automatic int bitrev(input int i, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) r = r | (((i >> b) & 1) << (bits - 1 - b));
        return r;
    endfunction
endpackage

// File: rtl/fft_iter_if.sv
// fft_iter_if: parallel sample/result bus with start/done handshake for fft_iter.
interface fft_iter_if #(
    parameter int LOG2N = 2,
    parameter int WIDTH = 32
);
    localparam int N = 1 << LOG2N;
    logic [WIDTH-1:0] samples [0:N-1];
    logic start;
    logic inverse;
    logic [WIDTH-1:0] frequencies [0:N-1];
    logic done;
    logic busy;
    modport master (output samples, start, inverse, input frequencies, done, busy);
    modport slave (input samples, start, inverse, output frequencies, done, busy);
endinterface

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: cos/sin of 2*pi*idx/N in Q1.(H-2), tabulated at elaboration.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N = 2,
    parameter int H = 16
) (
    input  logic [LOG2N-2:0]    idx_i,
    output logic signed [H-1:0] cos_o,
    output logic signed [H-1:0] sin_o
);
    localparam int N = 1 << LOG2N;
    localparam real ONE = 2.0 ** tw_frac(H);
    logic signed [H-1:0] cos_t [0:N/2-1];
    logic signed [H-1:0] sin_t [0:N/2-1];
    for (genvar i = 0; i < N / 2; i++) begin : g_tab
        localparam real ANG = 2.0 * PI * i / N;
        assign cos_t[i] = H'($rtoi($floor($cos(ANG) * ONE + 0.5)));
        assign sin_t[i] = H'($rtoi($floor($sin(ANG) * ONE + 0.5)));
    end
    assign cos_o = cos_t[idx_i];
    assign sin_o = sin_t[idx_i];
endmodule

// File: rtl/fft_iter.sv
// fft_iter: iterative in-place radix-2 DIT FFT/IFFT, one time-shared butterfly per clock.
module fft_iter
    import fft_pkg::*;
#(
    parameter int LOG2N = 2,
    parameter int WIDTH = 32,
    parameter int SCALE = 0
) (
    input  logic      clk,
    input  logic      reset_n,
    fft_iter_if.slave io
);
    localparam int N = 1 << LOG2N;
    localparam int H = WIDTH / 2;
    localparam int KW = LOG2N - 1;
    localparam int FRAC = tw_frac(H);
    localparam int P = 2 * H + 2;
    localparam logic signed [P-1:0] RND = P'(1) <<< (FRAC - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [3:0] S_LAST = 4'(LOG2N - 1);

    state_t state_q;
    logic [WIDTH-1:0] buf_q [0:N-1];
    logic [3:0] stage_q;
    logic [KW-1:0] k_q;
    logic inv_q, done_q, busy_q;

    int s;
    logic [LOG2N-1:0] kk, mask, p, q;
    logic [KW-1:0] tw_idx;
    logic signed [H-1:0] tw_cos, tw_sin;
    logic [WIDTH-1:0] a, b, bfp_d, bfq_d;
    logic signed [H-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [P-1:0] prod_re, prod_im;
    logic signed [H:0] t_re, t_im;
    logic [H:0] s_re, s_im, d_re, d_im;

    // p is k with a zero bit inserted at position s; q sets that bit.
    always_comb begin
        s = int'(stage_q);
        kk = {1'b0, k_q};
        mask = LOG2N'((1 << s) - 1);
        p = ((kk & ~mask) << 1) | (kk & mask);
        q = p | (LOG2N'(1) << s);
        tw_idx = KW'((kk & mask) << (LOG2N - 1 - s));
    end

    fft_twiddle_rom #(.LOG2N(LOG2N), .H(H)) u_rom (
        .idx_i(tw_idx),
        .cos_o(tw_cos),
        .sin_o(tw_sin)
    );

    always_comb begin
        a = buf_q[p];
        b = buf_q[q];
        a_re = H'(c_re(CMAX'(a), H));
        a_im = H'(c_im(CMAX'(a), H));
        b_re = H'(c_re(CMAX'(b), H));
        b_im = H'(c_im(CMAX'(b), H));
        w_re = tw_cos;
        w_im = inv_q ? tw_sin : -tw_sin;
        prod_re = P'(b_re) * P'(w_re) - P'(b_im) * P'(w_im) + RND;
        prod_im = P'(b_re) * P'(w_im) + P'(b_im) * P'(w_re) + RND;
        t_re = (H+1)'(prod_re >>> FRAC);
        t_im = (H+1)'(prod_im >>> FRAC);
        s_re = {a_re[H-1], a_re} + t_re;
        s_im = {a_im[H-1], a_im} + t_im;
        d_re = {a_re[H-1], a_re} - t_re;
        d_im = {a_im[H-1], a_im} - t_im;
        bfp_d = WIDTH'(c_pack(half_t'(SCALE != 0 ? s_re[H:1] : s_re[H-1:0]),
                              half_t'(SCALE != 0 ? s_im[H:1] : s_im[H-1:0]), H));
        bfq_d = WIDTH'(c_pack(half_t'(SCALE != 0 ? d_re[H:1] : d_re[H-1:0]),
                              half_t'(SCALE != 0 ? d_im[H:1] : d_im[H-1:0]), H));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q <= '0;
            inv_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (io.start) begin
                    for (int i = 0; i < N; i++) buf_q[LOG2N'(bitrev(i, LOG2N))] <= io.samples[i];
                    inv_q <= io.inverse;
                    stage_q <= '0;
                    k_q <= '0;
                    done_q <= 1'b0;
                    busy_q <= 1'b1;
                    state_q <= COMPUTE;
                end
                COMPUTE: begin
                    buf_q[p] <= bfp_d;
                    buf_q[q] <= bfq_d;
                    k_q <= k_q == K_LAST ? '0 : k_q + KW'(1);
                    if (k_q == K_LAST && stage_q == S_LAST) begin
                        state_q <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (k_q == K_LAST) begin
                        stage_q <= stage_q + 4'd1;
                    end
                end
                DONE: if (!io.start) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.frequencies = buf_q;
    assign io.done = done_q;
    assign io.busy = busy_q;
endmodule

// File: tb/tb_fft_iter.sv
// tb_fft_iter: directed vectors on three fft_iter configs, scoreboard checked on each done rise.
module tb_fft_iter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] smp [8];
    logic [31:0] eb [8];
    logic [2:0] st;
    logic inv;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] b [8];
        string tag;
    } exp_t;
    exp_t sb0[$], sb1[$], sb2[$];

    fft_iter_if #(.LOG2N(2), .WIDTH(32)) if0 ();
    fft_iter_if #(.LOG2N(2), .WIDTH(32)) if1 ();
    fft_iter_if #(.LOG2N(3), .WIDTH(32)) if2 ();

    fft_iter #(.LOG2N(2), .WIDTH(32), .SCALE(0)) dut0 (.clk(clk), .reset_n(reset_n), .io(if0));
    fft_iter #(.LOG2N(2), .WIDTH(32), .SCALE(1)) dut1 (.clk(clk), .reset_n(reset_n), .io(if1));
    fft_iter #(.LOG2N(3), .WIDTH(32), .SCALE(0)) dut2 (.clk(clk), .reset_n(reset_n), .io(if2));

    for (genvar i = 0; i < 4; i++) begin : g4
        assign if0.samples[i] = smp[i];
        assign if1.samples[i] = smp[i];
    end
    for (genvar i = 0; i < 8; i++) begin : g8
        assign if2.samples[i] = smp[i];
    end
    assign if0.start = st[0];
    assign if1.start = st[1];
    assign if2.start = st[2];
    assign if0.inverse = inv;
    assign if1.inverse = inv;
    assign if2.inverse = inv;

    function automatic logic [31:0] mk(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic logic dn(input int d);
        return d == 0 ? if0.done : d == 1 ? if1.done : if2.done;
    endfunction

    function automatic logic bz(input int d);
        return d == 0 ? if0.busy : d == 1 ? if1.busy : if2.busy;
    endfunction

    function automatic logic [31:0] bin(input int d, input int i);
        logic [1:0] i4;
        logic [2:0] i8;
        i4 = i[1:0];
        i8 = i[2:0];
        return d == 0 ? if0.frequencies[i4] : d == 1 ? if1.frequencies[i4] : if2.frequencies[i8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 8; i++) begin
            smp[i] = '0;
            eb[i] = '0;
        end
    endtask

    task automatic push(input int d, input string tag);
        exp_t e;
        e.tag = tag;
        for (int i = 0; i < 8; i++) e.b[i] = eb[i];
        case (d)
            0: sb0.push_back(e);
            1: sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic check_out(input int d);
        exp_t e;
        int sz;
        sz = d == 0 ? sb0.size() : d == 1 ? sb1.size() : sb2.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected done dut%0d: got done=1 expected no result pending", d);
        end else begin
            case (d)
                0: e = sb0.pop_front();
                1: e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            for (int i = 0; i < (d == 2 ? 8 : 4); i++)
                chk($sformatf("%s bin%0d", e.tag, i), bin(d, i), e.b[i]);
        end
    endtask

    // Monitor: compares a result every time a DUT raises done.
    initial begin
        logic [2:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (dn(d) && !prev[d]) check_out(d);
                prev[d] = dn(d);
            end
        end
    end

    task automatic run(input int d, input logic iv, input string tag, input int lat_exp, input bit tog);
        int lat, bc;
        push(d, tag);
        @(negedge clk);
        inv = iv;
        st[d] = 1'b1;
        @(posedge clk);
        #1;
        bc = bz(d) ? 1 : 0;
        lat = 0;
        while (!dn(d) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bz(d)) bc++;
            if (tog && !dn(d)) begin
                st[d] = lat[0];
                inv = ~inv;
                smp[0] = smp[0] + 32'h0001_0001;
            end
        end
        st[d] = 1'b0;
        chk({tag, " latency"}, lat, lat_exp);
        chk({tag, " busy cycles"}, bc, lat_exp);
        repeat (2) @(posedge clk);
    endtask

    task automatic load_t1();
        clr();
        smp[0] = mk(100, 0); smp[1] = mk(150, 0); smp[2] = mk(200, 0); smp[3] = mk(250, 0);
        eb[0] = mk(700, 0); eb[1] = mk(-100, 100); eb[2] = mk(-100, 0); eb[3] = mk(-100, -100);
    endtask

    initial begin
        inv = 1'b0;
        st = '0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset done dut%0d", d), 32'(dn(d)), 0);
            chk($sformatf("reset busy dut%0d", d), 32'(bz(d)), 0);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("reset bin%0d", i), bin(0, i), 0);
        @(negedge clk);
        reset_n = 1'b1;

        load_t1();
        run(0, 1'b0, "fwd ramp", 4, 1'b0);

        clr();
        smp[0] = mk(15, 0); smp[1] = mk(66, 0); smp[2] = mk(128, 0); smp[3] = mk(52, 0);
        eb[0] = mk(261, 0); eb[1] = mk(-113, -14); eb[2] = mk(25, 0); eb[3] = mk(-113, 14);
        run(0, 1'b0, "fwd mixed", 4, 1'b0);

        load_t1();
        run(0, 1'b0, "start toggled", 4, 1'b1);

        load_t1();
        eb[0] = mk(175, 0); eb[1] = mk(-25, 25); eb[2] = mk(-25, 0); eb[3] = mk(-25, -25);
        run(1, 1'b0, "scaled", 4, 1'b0);

        clr();
        smp[0] = mk(700, 0); smp[1] = mk(-100, 100); smp[2] = mk(-100, 0); smp[3] = mk(-100, -100);
        eb[0] = mk(400, 0); eb[1] = mk(600, 0); eb[2] = mk(800, 0); eb[3] = mk(1000, 0);
        run(0, 1'b1, "inverse", 4, 1'b0);

        clr();
        smp[0] = mk(1000, 0);
        for (int i = 0; i < 8; i++) eb[i] = mk(1000, 0);
        run(2, 1'b0, "n8 impulse", 12, 1'b0);

        clr();
        for (int i = 0; i < 8; i++) smp[i] = mk(100, 0);
        eb[0] = mk(800, 0);
        run(2, 1'b0, "n8 flat", 12, 1'b0);

        // Abort mid-transform: async reset must clear everything at once.
        load_t1();
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("busy before reset", 32'(bz(0)), 1);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("mid reset bin%0d", i), bin(0, i), 0);
        chk("mid reset done", 32'(dn(0)), 0);
        chk("mid reset busy", 32'(bz(0)), 0);
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after reset done", 32'(dn(0)), 0);
        chk("idle after reset bin0", bin(0, 0), 0);

        load_t1();
        run(0, 1'b0, "after reset", 4, 1'b0);

        chk("sb0 drained", sb0.size(), 0);
        chk("sb1 drained", sb1.size(), 0);
        chk("sb2 drained", sb2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
